// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the ROM combinationally and
// holds one fetched instruction for decode behind a valid/ready handshake.
module fetch_ctrl #(
  parameter int                 ADDR_W     = 5,
  parameter int                 DATA_W     = 32,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0,
  parameter logic [DATA_W-1:0]  HALT_WORD  = 32'h0000007f,
  parameter int                 CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              running,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t              state_q, state_n;
  logic [ADDR_W-1:0]   pc_q, pc_n;
  logic                valid_q, valid_n;
  logic [DATA_W-1:0]   inst_q, inst_n;
  logic [ADDR_W-1:0]   ipc_q, ipc_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic                slot_free;
  logic                handshake;

  // Handshake: an instruction transfers on a rising edge where inst_valid and
  // inst_ready are both high; while valid is high and ready is low, inst and
  // inst_pc hold. Only a redirect may withdraw valid before it is accepted.
  assign slot_free = !valid_q || inst_ready;
  assign handshake = valid_q && inst_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= START_ADDR;
      valid_q <= 1'b0;
      inst_q  <= '0;
      ipc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      valid_q <= valid_n;
      inst_q  <= inst_n;
      ipc_q   <= ipc_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    valid_n = valid_q;
    inst_n  = inst_q;
    ipc_n   = ipc_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_n    = START_ADDR;
          state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        // A delivery counts even when a redirect flushes in the same cycle.
        if (handshake && cnt_q != {CNT_W{1'b1}}) cnt_n = cnt_q + CNT_W'(1);
        if (redirect_valid) begin
          valid_n = 1'b0;
          pc_n    = redirect_addr;
        end else if (slot_free && rom_q == HALT_WORD) begin
          valid_n = 1'b0;
          state_n = S_HALT;
        end else if (slot_free) begin
          inst_n  = rom_q;
          ipc_n   = pc_q;
          valid_n = 1'b1;
          pc_n    = pc_q + ADDR_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign rom_addr    = pc_q;
  assign inst_valid  = valid_q;
  assign inst        = inst_q;
  assign inst_pc     = ipc_q;
  assign running     = (state_q == S_FETCH);
  assign halted      = (state_q == S_HALT);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: ROM model, per-cycle reference model, and a
// scoreboard of delivered {pc, word} pairs checked by an independent monitor.
module tb_fetch_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam logic [DW-1:0] HALT = 32'h0000007f;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic          inst_valid;
  logic [DW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_ready = 1'b0;
  logic          running;
  logic          halted;
  logic [CW-1:0] fetch_count;

  logic [DW-1:0] rom [32];
  assign rom_q = rom[rom_addr];

  fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .START_ADDR('0), .HALT_WORD(HALT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_q(rom_q),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .running(running), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [AW+DW-1:0] exp_q[$];

  // reference model: 0 idle, 1 fetching, 2 halted
  int          m_st = 0;
  int          m_pc = 0;
  bit          m_v = 0;
  int          m_ipc = 0;
  logic [DW-1:0] m_iw = '0;
  int          m_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // advance the model by one clock edge with the given inputs
  task automatic model_step(input bit r, input bit s, input bit rv, input int ra, input bit rd);
    if (r) begin
      m_st = 0; m_pc = 0; m_v = 0; m_ipc = 0; m_iw = '0; m_cnt = 0;
    end else if (m_st == 1) begin
      if (m_v && rd) begin
        exp_q.push_back({AW'(m_ipc), m_iw});
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end
      if (rv) begin
        m_v = 0;
        m_pc = ra;
      end else if (!m_v || rd) begin
        if (rom[m_pc] == HALT) begin
          m_v = 0;
          m_st = 2;
        end else begin
          m_iw = rom[m_pc];
          m_ipc = m_pc;
          m_v = 1;
          m_pc = (m_pc + 1) % 32;
        end
      end
    end else if (s) begin
      m_pc = 0;
      m_st = 1;
    end
  endtask

  task automatic check_outputs();
    chk("rom_addr", 64'(rom_addr), 64'(m_pc));
    chk("inst_valid", 64'(inst_valid), 64'(m_v));
    if (m_v) begin
      chk("inst", 64'(inst), 64'(m_iw));
      chk("inst_pc", 64'(inst_pc), 64'(m_ipc));
      chk("no_halt_word_out", 64'(inst == HALT), 64'(0));
    end
    chk("running", 64'(running), 64'(m_st == 1));
    chk("halted", 64'(halted), 64'(m_st == 2));
    chk("fetch_count", 64'(fetch_count), 64'(m_cnt));
  endtask

  // drive one cycle (called #1 after a rising edge), then check after the next edge
  task automatic cyc(input bit r, input bit s, input bit rv, input int ra, input bit rd);
    rst = r; start = s; redirect_valid = rv; redirect_addr = AW'(ra); inst_ready = rd;
    model_step(r, s, rv, ra, rd);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // monitor: every accepted instruction must match the next scoreboard entry
  always @(negedge clk) begin
    if (rst === 1'b0 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got pc=%0d inst=%0h expected none", inst_pc, inst);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({inst_pc, inst} !== e) begin
          bad++;
          $display("FAIL sb_delivery: got pc=%0d inst=%0h expected pc=%0d inst=%0h",
                   inst_pc, inst, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      logic [DW-1:0] w;
      w = $urandom();
      if (w == HALT) w = 32'h00000013;
      rom[i] = w;
    end
    rom[0]  = 32'h00008293;
    rom[1]  = 32'h00f00313;
    rom[9]  = 32'h00291913;
    rom[11] = HALT;
    rom[31] = 32'h00000013;

    // reset state
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("reset_inst", 64'(inst), 64'(0));
    chk("reset_inst_pc", 64'(inst_pc), 64'(0));

    // straight-line run to the halt word with ready held high
    cyc(0, 1, 0, 0, 1);
    for (int i = 0; i < 40 && !halted; i++) cyc(0, 0, 0, 0, 1);
    chk("halt_reached", 64'(halted), 64'(1));
    chk("halt_rom_addr", 64'(rom_addr), 64'(11));
    chk("halt_count", 64'(fetch_count), 64'(11));
    cyc(0, 0, 1, 5, 1);
    chk("halt_ignores_redirect", 64'(rom_addr), 64'(11));

    // restart from halt with random back-pressure; count continues and saturates
    cyc(0, 1, 0, 0, 0);
    chk("restart_pc", 64'(rom_addr), 64'(0));
    for (int i = 0; i < 80 && !halted; i++) cyc(0, 0, 0, 0, 1'($urandom_range(0, 1)));
    chk("halt_reached_2", 64'(halted), 64'(1));
    chk("count_saturated", 64'(fetch_count), 64'(CNT_MAX));

    // redirect while word 2 is held unaccepted
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("w2_pc", 64'(inst_pc), 64'(2));
    cyc(0, 0, 1, 9, 0);
    chk("redir_flush", 64'(inst_valid), 64'(0));
    chk("redir_count", 64'(fetch_count), 64'(2));
    cyc(0, 0, 0, 0, 0);
    chk("redir_target", 64'(inst), 64'(32'h00291913));
    chk("redir_target_pc", 64'(inst_pc), 64'(9));

    // reset mid-fetch with valid held, then inputs ignored while idle
    cyc(1, 0, 1, 7, 1);
    chk("midrst_valid", 64'(inst_valid), 64'(0));
    chk("midrst_count", 64'(fetch_count), 64'(0));
    chk("midrst_addr", 64'(rom_addr), 64'(0));
    cyc(0, 0, 1, 7, 1);
    cyc(0, 0, 1, 3, 0);
    chk("idle_ignores", 64'(rom_addr), 64'(0));

    // wrap 31 -> 0
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 1, 31, 1);
    cyc(0, 0, 0, 0, 1);
    chk("wrap_31", 64'(inst_pc), 64'(31));
    cyc(0, 0, 0, 0, 1);
    chk("wrap_0", 64'(inst_pc), 64'(0));

    // redirect wins over a halt word on rom_q
    cyc(0, 0, 1, 11, 1);
    chk("at_halt_word", 64'(rom_q), 64'(HALT));
    cyc(0, 0, 1, 3, 1);
    chk("redirect_beats_halt", 64'(halted), 64'(0));
    cyc(0, 0, 0, 0, 1);
    chk("after_redirect_pc", 64'(inst_pc), 64'(3));

    // random mix of reset, start, redirect and back-pressure
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 500; i++) begin
      cyc(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 9) == 0), int'($urandom_range(0, 31)),
          1'($urandom_range(0, 2) != 0));
    end
    cyc(0, 0, 0, 0, 0);
    chk("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
